avoid_ctrl: RTL
===============

AVOID_CTRL -- requirements
Module: avoid_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000: CLK cycles per 1 ms tick (100 MHz CLK).
REQ-002 Parameter DEB_MS, default 20: obstacle debounce length, in ticks.
REQ-003 Parameter STOP_MS, default 100: dwell in STOP and in CHECK, in ticks.
REQ-004 Parameter BACK_MS, default 400: dwell in BACK, in ticks.
REQ-005 Parameter TURN_MS, default 300: dwell in TURN, in ticks.
REQ-006 Parameter MAX_TURNS, default 8: number of consecutive blocked checks that forces HALT.
REQ-007 Port CLK, input, 1: system clock. One clock; all logic on its rising edge.
REQ-008 Port RST_N, input, 1: reset. Asynchronous and active-low.
REQ-009 Port BLK, input, 1: obstacle flag from the ultrasonic stage; high means obstacle within 300 mm; asynchronous to CLK.
REQ-010 Port AUTO_EN, input, 1: high selects autonomous avoidance; low selects manual drive.
REQ-011 Port CMD, input, 3: manual command from the Bluetooth decoder.
REQ-012 Port MOTOR, output, 4: motor drive bits [3]=L_FWD, [2]=L_REV, [1]=R_FWD, [0]=R_REV.
REQ-013 Port STATE_O, output, 3: current state code: MANUAL=0, FWD=1, STOP=2, BACK=3, TURN=4, CHECK=5, HALT=6.
REQ-014 Port BLK_DEB, output, 1: debounced obstacle flag.

Function
REQ-015 BLK shall pass through a two-flop synchronizer before any use.
REQ-016 A tick counter shall wrap every TICK_DIV cycles and shall emit a one-cycle tick pulse on each wrap.
REQ-017 BLK_DEB shall toggle only after the synchronized BLK has differed from BLK_DEB on DEB_MS consecutive ticks; any agreeing sample shall clear the debounce count.
REQ-018 The phase timer shall clear on every state entry and shall increment on ticks; a timed state shall exit on the tick at which the timer reaches its dwell value.
REQ-019 MOTOR encodings: stop=0000, forward=1010, back=0101, left spin=0110, right spin=1001.
REQ-020 In MANUAL, CMD shall map as follows: 000 stop, 001 forward, 010 back, 011 left, 100 right, 101-111 stop.
REQ-021 In MANUAL, CMD=001 while BLK_DEB=1 shall drive stop; all other commands shall pass unchanged.
REQ-022 From MANUAL, AUTO_EN=1 shall cause entry to FWD on the next cycle.
REQ-023 In FWD, MOTOR shall be forward; BLK_DEB=1 shall cause entry to STOP on the next cycle.
REQ-024 In STOP, MOTOR shall be stop for STOP_MS, then the block shall enter BACK.
REQ-025 In BACK, MOTOR shall be back for BACK_MS, then the block shall enter TURN.
REQ-026 In TURN, MOTOR shall be left spin for TURN_MS, then the block shall enter CHECK.
REQ-027 In CHECK, MOTOR shall be stop for STOP_MS; on exit, BLK_DEB=0 shall select FWD and clear the turn count; BLK_DEB=1 shall increment the turn count and select TURN.
REQ-028 If the turn count reaches MAX_TURNS on CHECK exit, the block shall enter HALT instead of TURN.
REQ-029 In HALT, MOTOR shall be stop until AUTO_EN goes low.
REQ-030 AUTO_EN=0 in any state shall cause entry to MANUAL on the next cycle and shall clear the phase timer and the turn count; this rule has priority over every other transition.
REQ-031 MOTOR, STATE_O and BLK_DEB shall be registered; MOTOR shall reflect a new state in the same cycle STATE_O changes.
REQ-032 A BLK change during STOP, BACK or TURN shall not alter the sequence; only CHECK samples BLK_DEB.

Reset
REQ-033 RST_N low shall immediately force MOTOR=0000, STATE_O=0 (MANUAL), BLK_DEB=0, and all counters and synchronizer flops to 0, regardless of CLK.
REQ-034 After RST_N rises, the first tick shall occur TICK_DIV cycles later; reset mid-sequence shall abandon the sequence entirely.

Verification
Bench parameters: TICK_DIV=10, DEB_MS=3, STOP_MS=2, BACK_MS=4, TURN_MS=3, MAX_TURNS=2.
REQ-035 Scenario 1: AUTO_EN=1, BLK=0 -> STATE_O=1 and MOTOR=1010 one cycle later; both remain unchanged for 1000 cycles.
REQ-036 Scenario 2: BLK pulses high for 2 ticks -> BLK_DEB stays 0 and STATE_O stays 1; BLK held high for 4 ticks -> BLK_DEB=1 and STATE_O=2.
REQ-037 Scenario 3: obstacle in FWD, BLK cleared during TURN -> states STOP(2 ticks, 0000), BACK(4 ticks, 0101), TURN(3 ticks, 0110), CHECK(2 ticks), then FWD (1010).
REQ-038 Scenario 4: BLK held high throughout -> CHECK->TURN once, then after the second blocked CHECK STATE_O=6 and MOTOR=0000; AUTO_EN dropped -> STATE_O=0 next cycle.
REQ-039 Scenario 5: MANUAL with CMD=001: BLK_DEB=0 gives MOTOR=1010; BLK_DEB=1 gives 0000; CMD=010 with BLK_DEB=1 gives 0101; CMD=111 gives 0000.
REQ-040 Scenario 6: RST_N pulsed low between clock edges during BACK -> MOTOR=0000 and STATE_O=0 asynchronously; with AUTO_EN=1 after release, FWD is entered on the next cycle.

Source files
------------

// File: rtl/avoid_ctrl.sv
// Obstacle-avoidance controller: manual drive pass-through plus an autonomous
// stop/back/turn/check sequence driven by a debounced obstacle flag.
module avoid_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int DEB_MS    = 20,
  parameter int STOP_MS   = 100,
  parameter int BACK_MS   = 400,
  parameter int TURN_MS   = 300,
  parameter int MAX_TURNS = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BLK,
  input  logic       AUTO_EN,
  input  logic [2:0] CMD,
  output logic [3:0] MOTOR,
  output logic [2:0] STATE_O,
  output logic       BLK_DEB
);

  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = $clog2(DEB_MS + 1);
  localparam int TMAX = (BACK_MS > TURN_MS) ? ((BACK_MS > STOP_MS) ? BACK_MS : STOP_MS)
                                            : ((TURN_MS > STOP_MS) ? TURN_MS : STOP_MS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int NW   = $clog2(MAX_TURNS + 1);

  localparam logic [3:0] M_STOP  = 4'b0000;
  localparam logic [3:0] M_FWD   = 4'b1010;
  localparam logic [3:0] M_BACK  = 4'b0101;
  localparam logic [3:0] M_LEFT  = 4'b0110;
  localparam logic [3:0] M_RIGHT = 4'b1001;

  typedef enum logic [2:0] {
    S_MANUAL = 3'd0,
    S_FWD    = 3'd1,
    S_STOP   = 3'd2,
    S_BACK   = 3'd3,
    S_TURN   = 3'd4,
    S_CHECK  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic          blk_s1_q, blk_s2_q;
  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic [DW-1:0] deb_cnt_q;
  logic          blk_deb_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] dwell_last;
  logic          phase_done;
  logic [NW-1:0] turns_q, turns_d;
  logic [3:0]    motor_q, motor_d;

  assign tick = (tick_cnt_q == CW'(TICK_DIV - 1));

  // Synchronizer, tick divider and debouncer; the debouncer only samples on ticks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blk_s1_q   <= 1'b0;
      blk_s2_q   <= 1'b0;
      tick_cnt_q <= '0;
      deb_cnt_q  <= '0;
      blk_deb_q  <= 1'b0;
    end else begin
      blk_s1_q   <= BLK;
      blk_s2_q   <= blk_s1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
      if (tick) begin
        if (blk_s2_q != blk_deb_q) begin
          if (deb_cnt_q == DW'(DEB_MS - 1)) begin
            blk_deb_q <= ~blk_deb_q;
            deb_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
          end
        end else begin
          deb_cnt_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_MANUAL;
      timer_q <= '0;
      turns_q <= '0;
      motor_q <= M_STOP;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      turns_q <= turns_d;
      motor_q <= motor_d;
    end
  end

  always_comb begin
    dwell_last = '0;
    case (state_q)
      S_STOP, S_CHECK: dwell_last = TW'(STOP_MS - 1);
      S_BACK:          dwell_last = TW'(BACK_MS - 1);
      S_TURN:          dwell_last = TW'(TURN_MS - 1);
      default:         dwell_last = '0;
    endcase
  end

  assign phase_done = tick && (timer_q == dwell_last);

  always_comb begin
    state_d = state_q;
    turns_d = turns_q;
    if (!AUTO_EN) begin
      state_d = S_MANUAL;
      turns_d = '0;
    end else begin
      case (state_q)
        S_MANUAL: state_d = S_FWD;
        S_FWD:    if (blk_deb_q) state_d = S_STOP;
        S_STOP:   if (phase_done) state_d = S_BACK;
        S_BACK:   if (phase_done) state_d = S_TURN;
        S_TURN:   if (phase_done) state_d = S_CHECK;
        S_CHECK: begin
          if (phase_done) begin
            if (!blk_deb_q) begin
              state_d = S_FWD;
              turns_d = '0;
            end else begin
              turns_d = turns_q + NW'(1);
              state_d = (turns_q == NW'(MAX_TURNS - 1)) ? S_HALT : S_TURN;
            end
          end
        end
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_MANUAL;
      endcase
    end
  end

  // Timer restarts on every state change so each timed state gets a full dwell.
  always_comb begin
    timer_d = timer_q;
    if (!AUTO_EN || (state_d != state_q)) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Motor is decoded from the next state so it changes on the same edge as STATE_O.
  always_comb begin
    motor_d = M_STOP;
    case (state_d)
      S_MANUAL: begin
        case (CMD)
          3'b001:  motor_d = blk_deb_q ? M_STOP : M_FWD;
          3'b010:  motor_d = M_BACK;
          3'b011:  motor_d = M_LEFT;
          3'b100:  motor_d = M_RIGHT;
          default: motor_d = M_STOP;
        endcase
      end
      S_FWD:   motor_d = M_FWD;
      S_BACK:  motor_d = M_BACK;
      S_TURN:  motor_d = M_LEFT;
      default: motor_d = M_STOP;
    endcase
  end

  assign MOTOR   = motor_q;
  assign STATE_O = state_q;
  assign BLK_DEB = blk_deb_q;

endmodule
